// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller: multi-cycle MIPS sequencer with memory-ready stalls and wait timeout
module mips_multicycle_controller #(
  parameter int MEM_TIMEOUT    = 16,
  parameter bit ILLEGAL_AS_NOP = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       reg_jal,
  output logic       data_jal,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_src,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_READ = 4'd3, MEM_WB = 4'd4,
    MEM_WRITE = 4'd5, R_EXEC = 4'd6, R_WB = 4'd7, I_EXEC = 4'd8, I_WB = 4'd9,
    BRANCH = 4'd10, JUMP = 4'd11, JR = 4'd12, HALT = 4'd15
  } state_t;
  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b, OP_ADDI = 6'h08,
    OP_SLTI = 6'h0a, OP_ANDI = 6'h0c, OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_J = 6'h02, OP_JAL = 6'h03;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25,
    FN_SLT = 6'h2a, FN_JR = 6'h08;
  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic is_r, is_jr, is_mem, is_i, is_br, is_j, waiting, expired;
  logic [2:0] r_op, i_op;
  assign is_r   = opcode == OP_R && (funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
                  funct == FN_OR || funct == FN_SLT);
  assign is_jr  = opcode == OP_R && funct == FN_JR;
  assign is_mem = opcode == OP_LW || opcode == OP_SW;
  assign is_i   = opcode == OP_ADDI || opcode == OP_SLTI || opcode == OP_ANDI;
  assign is_br  = opcode == OP_BEQ || opcode == OP_BNE;
  assign is_j   = opcode == OP_J || opcode == OP_JAL;
  assign r_op   = funct == FN_SUB ? 3'd1 : funct == FN_AND ? 3'd2 : funct == FN_OR ? 3'd3 :
                  funct == FN_SLT ? 3'd4 : 3'd0;
  assign i_op   = opcode == OP_SLTI ? 3'd4 : opcode == OP_ANDI ? 3'd2 : 3'd0;
  assign waiting = state_q == FETCH || state_q == MEM_READ || state_q == MEM_WRITE;
  assign expired = waiting && !mem_ready && cnt_q == CW'(MEM_TIMEOUT - 1);
  assign state   = rst ? state_q : 4'd0;
  // Next state, wait counter and per-state datapath controls; everything held low during reset
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    pc_we       = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    reg_jal     = 1'b0;
    data_jal    = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 3'd0;
    pc_src      = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;
    if (rst) begin
      case (state_q)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_we     = mem_ready;
          state_d   = mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          alu_src_b = 2'b11;
          state_d   = is_r ? R_EXEC : is_jr ? JR : is_mem ? MEM_ADDR : is_i ? I_EXEC :
                      is_br ? BRANCH : is_j ? JUMP : ILLEGAL_AS_NOP ? FETCH : HALT;
          illegal_op = !(is_r || is_jr || is_mem || is_i || is_br || is_j);
          instr_done = illegal_op;
        end
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = opcode == OP_LW ? MEM_READ : MEM_WRITE;
        end
        MEM_READ: begin
          iord     = 1'b1;
          mem_read = 1'b1;
          state_d  = mem_ready ? MEM_WB : MEM_READ;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        MEM_WRITE: begin
          iord       = 1'b1;
          mem_write  = 1'b1;
          instr_done = mem_ready;
          state_d    = mem_ready ? FETCH : MEM_WRITE;
        end
        R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = r_op;
          state_d   = R_WB;
        end
        R_WB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = i_op;
          state_d   = I_WB;
        end
        I_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = 3'd1;
          pc_src     = 2'b01;
          pc_we      = opcode == OP_BEQ ? zero : !zero;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        JUMP: begin
          pc_src     = 2'b10;
          pc_we      = 1'b1;
          reg_write  = opcode == OP_JAL;
          reg_jal    = opcode == OP_JAL;
          data_jal   = opcode == OP_JAL;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        JR: begin
          pc_src     = 2'b11;
          pc_we      = 1'b1;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        HALT: state_d = HALT;
        default: state_d = FETCH;
      endcase
      if (expired) begin
        mem_timeout = 1'b1;
        instr_done  = 1'b1;
        state_d     = FETCH;
      end
      cnt_d = (waiting && !mem_ready && !expired) ? cnt_q + 1'b1 : '0;
    end
  end
  // State and wait-counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
